// File: rtl/pc_display_pkg.sv
// Shared types and constants for the program-counter display controller.
//   NUM_DIGITS / DIGIT_W : display geometry (six hex nibbles)
//   disp_state_e         : RUN / HOLD display mode
//   lead_zero_blank()    : blank mask for leading-zero suppression
package pc_display_pkg;

    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned DISP_W     = NUM_DIGITS * DIGIT_W;

    typedef enum logic {
        StRun  = 1'b0,
        StHold = 1'b1
    } disp_state_e;

    // Digit i>0 is dark when it and every more-significant nibble are zero;
    // digit 0 always stays lit so a zero value still shows "0".
    function automatic logic [NUM_DIGITS-1:0] lead_zero_blank(input logic [DISP_W-1:0] d);
        logic [NUM_DIGITS-1:0] b;
        logic                  all_zero;
        b        = '0;
        all_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            all_zero = all_zero & (d[i*DIGIT_W +: DIGIT_W] == '0);
            b[i]     = all_zero;
        end
        return b;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus level debouncer for an active-low push button.
//   clk, rst : system clock, asynchronous active-high reset
//   key_n    : raw active-low key, asynchronous to clk
//   level    : accepted (debounced) key level, 1 = released
//   press    : one-cycle event on an accepted 1->0 transition
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             differs, at_limit;

    assign differs  = (sync2_q != level_q);
    assign at_limit = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (differs) begin
            if (at_limit) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    // Asserted in the cycle whose edge commits the new low level; register-only inputs.
    assign press = differs && at_limit && !sync2_q;

endmodule

// File: rtl/pc_display_ctrl.sv
// Periodically captures pc_in[23:0] for a six-digit hex display; a debounced
// key toggles between live refresh (RUN) and a frozen display (HOLD).
// Optional feature macro: LEADING_ZERO_BLANK_EN (leading-zero blanking).
//   clk, rst     : system clock, asynchronous active-high reset
//   pc_in        : program counter, bits [23:0] displayed
//   hold_key_n   : raw active-low hold key
//   digits       : six nibbles, digit i = bits [4i+3:4i]
//   blank        : per-digit blank request (1 = dark)
//   held         : 1 while the display is frozen
//   update_pulse : one-cycle strobe after each capture
module pc_display_ctrl
    import pc_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV     = 1000000,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           pc_in,
    input  logic                  hold_key_n,
    output logic [DISP_W-1:0]     digits,
    output logic [NUM_DIGITS-1:0] blank,
    output logic                  held,
    output logic                  update_pulse
);

    localparam int unsigned RW = $clog2(REFRESH_DIV);

    disp_state_e       state_q, state_d;
    logic [RW-1:0]     ref_cnt_q, ref_cnt_d;
    logic [DISP_W-1:0] digits_q;
    logic              pulse_q;
    logic              press;
    logic              terminal;
    logic              unused_key_level;
    logic [7:0]        unused_pc_hi;

    assign unused_pc_hi = pc_in[31:DISP_W];

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk   (clk),
        .rst   (rst),
        .key_n (hold_key_n),
        .level (unused_key_level),
        .press (press)
    );

    // Terminal count is only meaningful in RUN; HOLD parks the counter at 0.
    assign terminal = (state_q == StRun) && (ref_cnt_q == RW'(REFRESH_DIV - 1));

    always_comb begin
        state_d   = state_q;
        ref_cnt_d = '0;
        if (press) begin
            state_d = (state_q == StRun) ? StHold : StRun;
        end
        // Entering HOLD or returning to RUN both leave the counter at 0, so
        // the first capture after HOLD->RUN lands REFRESH_DIV cycles later.
        if ((state_q == StRun) && (state_d == StRun) && !terminal) begin
            ref_cnt_d = ref_cnt_q + RW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StRun;
            ref_cnt_q <= '0;
            digits_q  <= '0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ref_cnt_q <= ref_cnt_d;
            pulse_q   <= terminal;
            if (terminal) begin
                digits_q <= pc_in[DISP_W-1:0];
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] blank_q;

    // Computed from the incoming value so the mask lands on the same edge as digits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_q <= lead_zero_blank('0);
        end else if (terminal) begin
            blank_q <= lead_zero_blank(pc_in[DISP_W-1:0]);
        end
    end

    assign blank = blank_q;
`else
    assign blank = '0;
`endif

    assign digits       = digits_q;
    assign held         = (state_q == StHold);
    assign update_pulse = pulse_q;

endmodule

// File: tb/tb_pc_display_ctrl.sv
// Scoreboard bench for pc_display_ctrl (REFRESH_DIV=4, DEBOUNCE_CYCLES=3).
// A reference model predicts every capture and pushes it into a queue; a
// negedge monitor pops and compares whenever update_pulse is seen.
module tb_pc_display_ctrl;

    localparam int R = 4;
    localparam int D = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        hold_key_n;
    logic [23:0] digits;
    logic [5:0]  blank;
    logic        held;
    logic        update_pulse;

    always #5 clk = ~clk;

    pc_display_ctrl #(
        .REFRESH_DIV     (R),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_in        (pc_in),
        .hold_key_n   (hold_key_n),
        .digits       (digits),
        .blank        (blank),
        .held         (held),
        .update_pulse (update_pulse)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_k;          // edges since reset
    int          m_run_start;  // edge at which RUN (re)started
    bit          m_hold;
    bit          m_pulse;
    bit          m_acc;
    logic [23:0] m_digits;
    logic [5:0]  m_blank;
    bit          key_hist[$];  // raw key samples not yet through the synchronizer
    bit          syn_hist[$];  // last D synchronized samples
    logic [29:0] exp_q[$];     // {digits, blank}

    function automatic logic [5:0] exp_blank(input logic [23:0] d);
`ifdef LEADING_ZERO_BLANK_EN
        int         top;
        logic [5:0] b;
        top = -1;
        for (int i = 0; i < 6; i++) if (d[4*i +: 4] != 4'h0) top = i;
        b = 6'b0;
        for (int i = 1; i < 6; i++) if (i > top) b[i] = 1'b1;
        return b;
`else
        return 6'b0;
`endif
    endfunction

    task automatic model_reset();
        m_k = 0;
        m_run_start = 0;
        m_hold = 0;
        m_pulse = 0;
        m_acc = 1;
        m_digits = 24'h0;
        m_blank = exp_blank(24'h0);
        key_hist = '{1'b1, 1'b1};
        syn_hist.delete();
        exp_q.delete();
    endtask

    task automatic model_step();
        bit s2, all_diff, press_ev, capture;
        m_k++;
        s2 = key_hist.pop_front();
        key_hist.push_back(hold_key_n);
        syn_hist.push_back(s2);
        if (syn_hist.size() > D) void'(syn_hist.pop_front());
        // Accept a new level once the last D synchronized samples all disagree.
        all_diff = (syn_hist.size() == D);
        foreach (syn_hist[i]) if (syn_hist[i] == m_acc) all_diff = 0;
        press_ev = 0;
        if (all_diff) begin
            m_acc = s2;
            press_ev = (s2 == 1'b0);
        end
        capture = !m_hold && (((m_k - m_run_start) % R) == 0);
        m_pulse = capture;
        if (capture) begin
            m_digits = pc_in[23:0];
            m_blank = exp_blank(pc_in[23:0]);
            exp_q.push_back({m_digits, m_blank});
        end
        if (press_ev) begin
            if (m_hold) begin
                m_hold = 0;
                m_run_start = m_k;
            end else begin
                m_hold = 1;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [29:0] e;
        forever begin
            @(negedge clk);
            check("update_pulse", {31'b0, update_pulse}, {31'b0, m_pulse});
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (update_pulse) begin
                    check("captured digits", {8'h0, digits}, {8'h0, e[29:6]});
                    check("captured blank", {26'h0, blank}, {26'h0, e[5:0]});
                end
            end
            check("held", {31'b0, held}, {31'b0, m_hold});
            check("digits", {8'h0, digits}, {8'h0, m_digits});
            check("blank", {26'h0, blank}, {26'h0, m_blank});
        end
    end

    // ---------------- stimulus ----------------
    task automatic count_to_pulse(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!update_pulse && n < 50);
    endtask

    task automatic count_to_held(input bit want, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (held !== want && n < 50);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " digits"}, {8'h0, digits}, 32'h0);
        check({tag, " held"}, {31'b0, held}, 32'h0);
        check({tag, " update_pulse"}, {31'b0, update_pulse}, 32'h0);
        check({tag, " blank"}, {26'h0, blank}, {26'h0, exp_blank(24'h0)});
    endtask

    task automatic mid_reset(input string tag);
        int n;
        #2 rst = 1'b1;
        #1 check_reset_outputs(tag);
        @(negedge clk);
        hold_key_n = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        count_to_pulse(n);
        check({tag, " first pulse latency"}, n, 4);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, pulses;
        rst = 1'b1;
        hold_key_n = 1'b1;
        pc_in = 32'h00401234;
        #1 check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Steady value: capture every R cycles.
        count_to_pulse(n);
        check("first pulse latency", n, 4);
        check("digits 401234", {8'h0, digits}, 32'h00401234);
        check("blank 401234", {26'h0, blank}, {26'h0, exp_blank(24'h401234)});
        count_to_pulse(n);
        check("pulse period", n, 4);

        pc_in = 32'h00000050;
        count_to_pulse(n);
        check("digits 000050", {8'h0, digits}, 32'h00000050);
        check("blank 000050", {26'h0, blank}, {26'h0, exp_blank(24'h000050)});

        // Glitch shorter than the debounce window is ignored.
        hold_key_n = 1'b0;
        repeat (2) @(negedge clk);
        hold_key_n = 1'b1;
        repeat (8) @(negedge clk);
        check("short press ignored", {31'b0, held}, 32'h0);

        // Real press: 2 sync + 3 debounce edges.
        hold_key_n = 1'b0;
        count_to_held(1'b1, n);
        check("hold latency", n, 5);
        @(negedge clk);
        hold_key_n = 1'b1;
        pc_in = 32'h00ABCDEF;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (update_pulse) pulses++;
        end
        check("no pulses in hold", pulses, 0);
        check("digits frozen", {8'h0, digits}, 32'h00000050);

        // Second press resumes; first capture exactly R cycles later.
        hold_key_n = 1'b0;
        count_to_held(1'b0, n);
        check("resume latency", n, 5);
        count_to_pulse(n);
        check("resume first pulse", n, 4);
        check("digits ABCDEF", {8'h0, digits}, 32'h00ABCDEF);
        hold_key_n = 1'b1;
        repeat (8) @(negedge clk);

        // Press landing on the terminal-count edge.
        pc_in = 32'hFF000007;
        n = 0;
        while ((((m_k + 5 - m_run_start) % R) != 0) && n < 8) begin
            @(negedge clk);
            n++;
        end
        hold_key_n = 1'b0;
        repeat (5) @(negedge clk);
        check("coincident pulse", {31'b0, update_pulse}, 32'h1);
        check("coincident held", {31'b0, held}, 32'h1);
        check("coincident digits", {8'h0, digits}, 32'h00000007);
        @(negedge clk);
        hold_key_n = 1'b1;

        // Randomized key activity and pc values.
        for (int s = 0; s < 60; s++) begin
            hold_key_n = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: pc_in = $urandom;
                1: pc_in = $urandom & 32'h0000FFFF;
                2: pc_in = $urandom & 32'h000000FF;
                default: pc_in = 32'h0;
            endcase
            repeat ($urandom_range(1, 8)) @(negedge clk);
        end
        hold_key_n = 1'b1;
        repeat (10) @(negedge clk);

        // Reset mid-debounce, then mid-refresh.
        hold_key_n = 1'b0;
        repeat (2) @(negedge clk);
        mid_reset("rst mid-debounce");
        repeat (2) @(negedge clk);
        mid_reset("rst mid-refresh");

        repeat (10) @(negedge clk);
        check("scoreboard drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_display_ctrl.md
PC_DISPLAY_CTRL -- requirements
Module: pc_display_ctrl

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 1000000, clk cycles between display captures (legal values 2 and above).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000, cycles a key level must be stable before it is accepted (legal values 2 and above).
REQ-003 SHALL have port clk, input, 1, single system clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port pc_in, input, 32, program counter from sc_computer; bits [23:0] used.
REQ-006 SHALL have port hold_key_n, input, 1, raw active-low push button, asynchronous to clk.
REQ-007 SHALL have port digits, output, 24, six 4-bit nibbles for segdriver 0..5 (digit i = bits [4i+3:4i]).
REQ-008 SHALL have port blank, output, 6, per-digit blank request (1 = segdriver i dark).
REQ-009 SHALL have port held, output, 1, 1 while display frozen.
REQ-010 SHALL have port update_pulse, output, 1, one-cycle strobe on each capture.

Function
REQ-011 SHALL pass hold_key_n through a 2-flop synchronizer before any other use.
REQ-012 Debounce SHALL count consecutive cycles where synced level differs from accepted level; the counter resets whenever the levels are equal; when the count reaches DEBOUNCE_CYCLES-1, the accepted level SHALL update on that edge and the counter SHALL clear.
REQ-013 A press SHALL be an accepted 1->0 transition; it SHALL produce a one-cycle internal press event; a release SHALL produce no event.
REQ-014 The FSM SHALL have two states: RUN and HOLD. A press event toggles RUN<->HOLD; held SHALL equal (state==HOLD), registered.
REQ-015 In RUN, the refresh counter SHALL count 0..REFRESH_DIV-1 and wrap. On the terminal-count cycle, digits SHALL load pc_in[23:0] and update_pulse SHALL be 1 in the following cycle (registered).
REQ-016 In HOLD, the refresh counter SHALL be held at 0, digits SHALL be frozen, and update_pulse SHALL be 0.
REQ-017 On HOLD->RUN, counting SHALL restart from 0; the first capture SHALL occur REFRESH_DIV cycles after the transition edge.
REQ-018 If a press event coincides with terminal count in RUN, the capture SHALL still occur and the state SHALL enter HOLD on the same edge.
REQ-019 blank SHALL be registered and SHALL update on the same edge as digits, with no extra latency.

Reset
REQ-020 On rst: state=RUN, counters=0, synchronizer and accepted level=1, digits=0, held=0, update_pulse=0, blank as per REQ-022/023.
REQ-021 Assertion of rst mid-debounce or mid-refresh SHALL abandon the operation; no pulse or press event SHALL be emitted.

Configuration
REQ-022 With LEADING_ZERO_BLANK_EN defined: blank[i]=1 for every digit i>0 whose nibble and all higher nibbles are 0; blank[0] SHALL always be 0; the reset value SHALL be 6'b111110.
REQ-023 Without LEADING_ZERO_BLANK_EN: blank SHALL be constant 0, including during reset, and no blanking logic SHALL be synthesized.

Structure
REQ-024 Package pc_display_pkg SHALL hold the RUN/HOLD state typedef, NUM_DIGITS=6 and DIGIT_W=4.
REQ-025 Synchronizer and debounce logic SHALL be a sub-module key_debounce (outputs: accepted level, press pulse), instantiated once.

Verification (REFRESH_DIV=4, DEBOUNCE_CYCLES=3)
REQ-026 Scenario: pc_in=32'h00401234 steady after reset -> digits=24'h401234, with update_pulse every 4 cycles; with the macro defined, blank=6'b000000.
REQ-027 Scenario: pc_in=32'h00000050 -> digits=24'h000050; with the macro defined, blank=6'b111100; without it, blank=0.
REQ-028 Scenario: a key low pulse of 2 cycles -> no state change; a key held low for 6 cycles -> held=1 after 2 sync + 3 debounce cycles; a later pc_in change is not reflected and update_pulse stays 0.
REQ-029 Scenario: release the key, then press again -> held=0; the first update_pulse comes exactly 4 cycles after the state edge and digits show the new pc_in.
REQ-030 Scenario: press timed to coincide with terminal count -> digits capture that cycle's pc_in and held=1 on the same edge.
REQ-031 Scenario: rst asserted mid-debounce and mid-refresh -> all outputs return to reset values asynchronously; no update_pulse after release until 4 cycles elapse.
